// File: rtl/voq_command_dispatch.sv
// rtl/voq_command_dispatch.sv - round-robin dispatcher from per-VOQ FWFT command FIFOs to a registered valid/ready output
module voq_command_dispatch #(
    parameter int NQ    = 4,
    parameter int WIDTH = 72,
    parameter int CNTW  = 16,
    localparam int QW   = (NQ > 1) ? $clog2(NQ) : 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NQ-1:0]         fifo_empty,
    input  logic [NQ*WIDTH-1:0]   fifo_dout,
    input  logic [NQ-1:0]         fifo_sberr,
    input  logic [NQ-1:0]         fifo_dberr,
    output logic [NQ-1:0]         fifo_re,
    output logic                  cmd_valid,
    input  logic                  cmd_ready,
    output logic [WIDTH-1:0]      cmd_data,
    output logic [QW-1:0]         cmd_qid,
    input  logic                  halt,
    output logic                  halted,
    output logic [CNTW-1:0]       sberr_cnt,
    output logic [CNTW-1:0]       dberr_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Pointer holds the last granted queue; the search starts one above it.
    logic [QW-1:0]     ptr;
    logic [QW-1:0]     grant;
    logic [QW-1:0]     cand;
    logic              any_head;

    logic              run_en;
    logic              out_free;
    logic              pop;

    logic [WIDTH-1:0]  head_data;
    logic              head_sb;
    logic              head_db;

    logic [CNTW-1:0]   cnt_max;

    assign cnt_max  = '1;

    // The output slot can take a new word if it is empty or its word leaves this cycle.
    assign out_free = !cmd_valid || cmd_ready;

    // State register for the halt/drain controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: halt stops popping first, then waits for the held word to leave.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_RUN: begin
                if (halt) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!halt) begin
                    state_nxt = ST_RUN;
                end else if (out_free) begin
                    state_nxt = ST_HALTED;
                end
            end
            ST_HALTED: begin
                if (!halt) begin
                    state_nxt = ST_RUN;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Controller outputs: popping is blocked in the very cycle halt is first seen.
    always_comb begin
        run_en = 1'b0;
        halted = 1'b0;
        case (state)
            ST_RUN:    run_en = !halt;
            ST_HALTED: halted = !cmd_valid;
            default: begin
                run_en = 1'b0;
                halted = 1'b0;
            end
        endcase
    end

    // Round-robin search: first non-empty head strictly after ptr, wrapping modulo NQ.
    always_comb begin
        grant    = '0;
        cand     = '0;
        any_head = 1'b0;
        for (int k = 1; k <= NQ; k++) begin
            cand = QW'((int'(ptr) + k) % NQ);
            if (!any_head && !fifo_empty[cand]) begin
                grant    = cand;
                any_head = 1'b1;
            end
        end
    end

    assign pop = !rst && run_en && out_free && any_head;

    // Select the granted head word and its ECC qualifiers.
    always_comb begin
        head_data = fifo_dout[int'(grant)*WIDTH +: WIDTH];
        head_sb   = fifo_sberr[grant];
        head_db   = fifo_dberr[grant];
    end

    // Combinational pop strobe: only the granted queue, and only when a pop happens.
    always_comb begin
        fifo_re = '0;
        if (pop) begin
            fifo_re[grant] = 1'b1;
        end
    end

    // Output stage, arbitration pointer and ECC counters; dberr words are popped but never shown.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
            cmd_qid   <= '0;
            ptr       <= QW'(NQ - 1);
            sberr_cnt <= '0;
            dberr_cnt <= '0;
        end else if (pop) begin
            ptr <= grant;
            if (head_db) begin
                cmd_valid <= 1'b0;
                if (dberr_cnt != cnt_max) begin
                    dberr_cnt <= dberr_cnt + CNTW'(1);
                end
            end else begin
                cmd_valid <= 1'b1;
                cmd_data  <= head_data;
                cmd_qid   <= grant;
                if (head_sb && (sberr_cnt != cnt_max)) begin
                    sberr_cnt <= sberr_cnt + CNTW'(1);
                end
            end
        end else if (cmd_ready) begin
            cmd_valid <= 1'b0;
        end
    end

`ifndef SYNTHESIS
    re_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(fifo_re));
    re_not_empty: assert property (@(posedge clk) disable iff (rst) ((fifo_re & fifo_empty) == '0));
    hold_stable: assert property (@(posedge clk) disable iff (rst)
        (cmd_valid && !cmd_ready) |=> ($stable(cmd_data) && $stable(cmd_qid)));
`endif

endmodule

// File: tb/tb_voq_command_dispatch.sv
// tb/tb_voq_command_dispatch.sv - scoreboard bench for voq_command_dispatch with a queue-level reference model
module tb_voq_command_dispatch;

    localparam int NQ    = 4;
    localparam int WIDTH = 72;
    localparam int CNTW  = 4;
    localparam int QW    = 2;
    localparam int SAT   = 15;

    localparam int M_RUN    = 0;
    localparam int M_DRAIN  = 1;
    localparam int M_HALTED = 2;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic             sb;
        logic             db;
    } ent_t;

    typedef struct packed {
        logic [WIDTH-1:0] d;
        logic [QW-1:0]    q;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic [NQ-1:0]        fifo_empty;
    logic [NQ*WIDTH-1:0]  fifo_dout;
    logic [NQ-1:0]        fifo_sberr;
    logic [NQ-1:0]        fifo_dberr;
    logic [NQ-1:0]        fifo_re;
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [WIDTH-1:0]     cmd_data;
    logic [QW-1:0]        cmd_qid;
    logic                 halt;
    logic                 halted;
    logic [CNTW-1:0]      sberr_cnt;
    logic [CNTW-1:0]      dberr_cnt;

    voq_command_dispatch #(
        .NQ    (NQ),
        .WIDTH (WIDTH),
        .CNTW  (CNTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_sberr (fifo_sberr),
        .fifo_dberr (fifo_dberr),
        .fifo_re    (fifo_re),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_data   (cmd_data),
        .cmd_qid    (cmd_qid),
        .halt       (halt),
        .halted     (halted),
        .sberr_cnt  (sberr_cnt),
        .dberr_cnt  (dberr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    ent_t mq [NQ][$];
    exp_t sbq[$];

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;

    int m_ptr;
    bit m_valid;
    int m_sb;
    int m_db;
    int m_mode;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_word();
        return {8'($urandom), $urandom, $urandom};
    endfunction

    task automatic push(input int q, input bit sb, input bit db);
        mq[q].push_back('{d: rand_word(), sb: sb, db: db});
    endtask

    task automatic drive_fifo();
        for (int i = 0; i < NQ; i++) begin
            if (mq[i].size() > 0) begin
                fifo_empty[i]                  = 1'b0;
                fifo_dout[i*WIDTH +: WIDTH]    = mq[i][0].d;
                fifo_sberr[i]                  = mq[i][0].sb;
                fifo_dberr[i]                  = mq[i][0].db;
            end else begin
                fifo_empty[i]                  = 1'b1;
                fifo_dout[i*WIDTH +: WIDTH]    = '0;
                fifo_sberr[i]                  = 1'b0;
                fifo_dberr[i]                  = 1'b0;
            end
        end
    endtask

    task automatic model_reset();
        m_ptr   = NQ - 1;
        m_valid = 1'b0;
        m_sb    = 0;
        m_db    = 0;
        m_mode  = M_RUN;
        sbq.delete();
    endtask

    // One clock: present FIFO heads, predict this edge from queue contents, then advance.
    task automatic step();
        int            g;
        int            nm;
        bit            any;
        bit            pop;
        logic [NQ-1:0] exp_re;
        ent_t          e;
        drive_fifo();
        #1;
        any = 1'b0;
        g   = 0;
        for (int k = 1; k <= NQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NQ;
            if (!any && mq[idx].size() > 0) begin
                any = 1'b1;
                g   = idx;
            end
        end
        pop    = !rst && (m_mode == M_RUN) && !halt && (!m_valid || cmd_ready) && any;
        exp_re = pop ? (NQ'(1) << g) : '0;
        chk("fifo_re", fifo_re, exp_re);
        if (fifo_re != '0) pulses++;
        if (rst) begin
            model_reset();
        end else begin
            chk("cmd_valid", cmd_valid, m_valid);
            chk("halted", halted, m_mode == M_HALTED);
            chk("sberr_cnt", sberr_cnt, m_sb);
            chk("dberr_cnt", dberr_cnt, m_db);
            nm = m_mode;
            case (m_mode)
                M_RUN:    if (halt) nm = M_DRAIN;
                M_DRAIN:  if (!halt) nm = M_RUN; else if (!m_valid || cmd_ready) nm = M_HALTED;
                default:  if (!halt) nm = M_RUN;
            endcase
            if (pop) begin
                e     = mq[g].pop_front();
                m_ptr = g;
                if (e.db) begin
                    if (m_db < SAT) m_db++;
                    m_valid = 1'b0;
                end else begin
                    sbq.push_back('{d: e.d, q: QW'(g)});
                    m_valid = 1'b1;
                    if (e.sb && m_sb < SAT) m_sb++;
                end
            end else if (cmd_ready) begin
                m_valid = 1'b0;
            end
            m_mode = nm;
        end
        @(negedge clk);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Monitor: every accepted output word must match the oldest predicted word.
    always @(negedge clk) begin
        exp_t e;
        #2;
        if (!rst && cmd_valid === 1'b1 && cmd_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_cmd: got qid %0d data %0h expected none", cmd_qid, cmd_data);
            end else begin
                e = sbq.pop_front();
                chk("cmd_data", cmd_data, e.d);
                chk("cmd_qid", cmd_qid, e.q);
            end
        end
    end

    initial begin
        int budget;
        rst        = 1'b1;
        cmd_ready  = 1'b0;
        halt       = 1'b0;
        fifo_empty = '1;
        fifo_dout  = '0;
        fifo_sberr = '0;
        fifo_dberr = '0;
        model_reset();
        @(negedge clk);
        steps(2);
        rst = 1'b0;

        chk("rst_valid", cmd_valid, 0);
        chk("rst_data", cmd_data, 0);
        chk("rst_qid", cmd_qid, 0);
        chk("rst_sberr", sberr_cnt, 0);
        chk("rst_dberr", dberr_cnt, 0);
        chk("rst_halted", halted, 0);
        chk("rst_re", fifo_re, 0);

        // Q0={A0,A1}, Q2={C0}: expect A0, C0, A1
        push(0, 0, 0); push(0, 0, 0); push(2, 0, 0);
        cmd_ready = 1'b1;
        steps(6);

        // Four queues of three: qid 0,1,2,3 repeated, twelve pops
        for (int r = 0; r < 3; r++) for (int q = 0; q < NQ; q++) push(q, 0, 0);
        pulses = 0;
        steps(16);
        chk("pulses_12", pulses, 12);

        // Back-pressure: one pop only while ready is low
        push(1, 0, 0); push(1, 0, 0);
        cmd_ready = 1'b0;
        pulses = 0;
        steps(5);
        chk("pulses_stall", pulses, 1);
        cmd_ready = 1'b1;
        steps(4);

        // ECC handling
        push(3, 0, 1); push(3, 0, 0);
        steps(4);
        chk("dberr_one", dberr_cnt, 1);
        push(0, 1, 0);
        steps(3);
        chk("sberr_one", sberr_cnt, 1);
        push(1, 1, 1);
        steps(3);
        chk("dberr_two", dberr_cnt, 2);
        chk("sberr_kept", sberr_cnt, 1);

        // Saturation: 18 dropped words on a 4-bit counter
        rst = 1'b1; step(); rst = 1'b0;
        for (int i = 0; i < 18; i++) push(i % NQ, 0, 1);
        steps(24);
        chk("dberr_sat", dberr_cnt, SAT);

        // Halt while a word is held
        push(2, 0, 0); push(2, 0, 0);
        cmd_ready = 1'b0;
        steps(2);
        halt = 1'b1;
        pulses = 0;
        steps(3);
        chk("halt_no_pop", pulses, 0);
        cmd_ready = 1'b1;
        step();
        chk("halted_rise", halted, 1);
        cmd_ready = 1'b0;
        steps(2);
        halt = 1'b0;
        cmd_ready = 1'b1;
        steps(3);

        // Reset mid-stream
        for (int q = 0; q < NQ; q++) push(q, q == 1, 0);
        steps(2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_valid", cmd_valid, 0);
        chk("midrst_sberr", sberr_cnt, 0);
        chk("midrst_dberr", dberr_cnt, 0);
        steps(6);

        // Randomized traffic with back-pressure and halt toggling
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) begin
                push($urandom_range(0, NQ - 1), $urandom_range(0, 7) == 0, $urandom_range(0, 9) == 0);
            end
            cmd_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 29) == 0) halt = ~halt;
            step();
        end

        // Drain everything and confirm nothing is left outstanding
        halt      = 1'b0;
        cmd_ready = 1'b1;
        budget    = 0;
        while ((mq[0].size() + mq[1].size() + mq[2].size() + mq[3].size() > 0 || m_valid) && budget < 300) begin
            step();
            budget++;
        end
        steps(2);
        chk("drain_budget", budget < 300, 1);
        chk("sb_empty", sbq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
